// File: rtl/max_scan_ctrl.sv
// max_scan_ctrl: scans a small entry buffer for its largest value.
// Ports: clk, rst_n (async active-low), wr_en/wr_addr/wr_data (buffer write),
//   start (scan request), busy, done (1-cycle pulse), max_val/max_idx (result).
// Option: define MAX_SCAN_TRACK_MIN_EN to add min_val/min_idx outputs.
module max_scan_ctrl #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         max_val,
`ifdef MAX_SCAN_TRACK_MIN_EN
  output logic [$clog2(DEPTH)-1:0] max_idx,
  output logic [WIDTH-1:0]         min_val,
  output logic [$clog2(DEPTH)-1:0] min_idx
`else
  output logic [$clog2(DEPTH)-1:0] max_idx
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_ptr;
  logic             r_fin;
  logic [WIDTH-1:0] r_best;
  logic [AW-1:0]    r_best_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_max_val;
  logic [AW-1:0]    r_max_idx;

  logic             w_ready;
  logic             w_accept;
  logic             w_wr_ok;
  logic [WIDTH-1:0] w_cur;
  logic             w_gt;

  assign w_ready  = (r_state == IDLE) || (r_state == DONE);
  assign w_accept = w_ready && start;
  // start wins over a same-cycle write
  assign w_wr_ok  = w_ready && wr_en && !start;
  assign w_cur    = r_mem[r_ptr];
  // strict compare: ties keep the lower index
  assign w_gt     = w_cur > r_best;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // r_fin marks the extra cycle after the last compare,
  // used to register the result together with done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_fin      <= 1'b0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_max_val  <= '0;
      r_max_idx  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (w_accept) begin
            r_state    <= SCAN;
            r_best     <= r_mem[0];
            r_best_idx <= '0;
            r_ptr      <= AW'(1);
            r_fin      <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= IDLE;
          end
        end
        SCAN: begin
          if (!r_fin) begin
            if (w_gt) begin
              r_best     <= w_cur;
              r_best_idx <= r_ptr;
            end
            // pointer stops at the last entry, never wraps
            if (r_ptr == LAST) begin
              r_fin <= 1'b1;
            end else begin
              r_ptr <= r_ptr + 1'b1;
            end
          end else begin
            r_state   <= DONE;
            r_fin     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_max_val <= r_best;
            r_max_idx <= r_best_idx;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_fin   <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign max_val = r_max_val;
  assign max_idx = r_max_idx;

`ifdef MAX_SCAN_TRACK_MIN_EN
  logic [WIDTH-1:0] r_bmin;
  logic [AW-1:0]    r_bmin_idx;
  logic [WIDTH-1:0] r_min_val;
  logic [AW-1:0]    r_min_idx;
  logic             w_lt;

  assign w_lt = r_bmin > w_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bmin     <= '0;
      r_bmin_idx <= '0;
      r_min_val  <= '0;
      r_min_idx  <= '0;
    end else if (w_accept) begin
      r_bmin     <= r_mem[0];
      r_bmin_idx <= '0;
    end else if (r_state == SCAN) begin
      if (!r_fin) begin
        if (w_lt) begin
          r_bmin     <= w_cur;
          r_bmin_idx <= r_ptr;
        end
      end else begin
        r_min_val <= r_bmin;
        r_min_idx <= r_bmin_idx;
      end
    end
  end

  assign min_val = r_min_val;
  assign min_idx = r_min_idx;
`endif

endmodule

// File: tb/tb_max_scan_ctrl.sv
// tb_max_scan_ctrl: directed vector table plus corner-case sequences
// for max_scan_ctrl (WIDTH=4, DEPTH=8).
module tb_max_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic [3:0] max_val;
  logic [2:0] max_idx;
`ifdef MAX_SCAN_TRACK_MIN_EN
  logic [3:0] min_val;
  logic [2:0] min_idx;
`endif

  always #5 clk = ~clk;

  max_scan_ctrl #(.WIDTH(4), .DEPTH(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .max_val (max_val),
`ifdef MAX_SCAN_TRACK_MIN_EN
    .max_idx (max_idx),
    .min_val (min_val),
    .min_idx (min_idx)
`else
    .max_idx (max_idx)
`endif
  );

  typedef struct {
    logic [31:0] ent;
    int          mx;
    int          mxi;
    int          mn;
    int          mni;
  } vec_t;

  vec_t vec [6];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    logic [31:0] av;
    logic [31:0] dv;
    av = a;
    dv = d;
    wr_en = 1'b1;
    wr_addr = av[2:0];
    wr_data = dv[3:0];
    step();
    wr_en = 1'b0;
  endtask

  task automatic load(input logic [31:0] e);
    for (int i = 0; i < 8; i++) begin
      wr(i, int'(e[i*4 +: 4]));
    end
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      step();
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic go(output int lat);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    wait_done(lat);
  endtask

  initial begin
    int lat;
    int nd;

    vec[0] = '{32'h170FF293, 15, 3, 0, 5};
    vec[1] = '{32'h55555555, 5, 0, 5, 0};
    vec[2] = '{32'h76543210, 7, 7, 0, 0};
    vec[3] = '{32'h89ABCDEF, 15, 0, 8, 7};
    vec[4] = '{32'h00000000, 0, 0, 0, 0};
    vec[5] = '{32'h12344321, 4, 3, 1, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_max_val", int'(max_val), 0);
    chk("rst_max_idx", int'(max_idx), 0);
    rst_n = 1'b1;
    step();

    for (int v = 0; v < 6; v++) begin
      load(vec[v].ent);
      go(lat);
      chk($sformatf("v%0d_latency", v), lat, 8);
      chk($sformatf("v%0d_max_val", v), int'(max_val), vec[v].mx);
      chk($sformatf("v%0d_max_idx", v), int'(max_idx), vec[v].mxi);
      chk($sformatf("v%0d_busy_in_done", v), int'(busy), 0);
`ifdef MAX_SCAN_TRACK_MIN_EN
      chk($sformatf("v%0d_min_val", v), int'(min_val), vec[v].mn);
      chk($sformatf("v%0d_min_idx", v), int'(min_idx), vec[v].mni);
`endif
    end

    // write and restart during SCAN are ignored
    load(32'h76543210);
    start = 1'b1;
    step();
    start = 1'b0;
    nd = 0;
    lat = -1;
    for (int n = 1; n <= 14; n++) begin
      if (n == 2) begin
        wr_en = 1'b1;
        wr_addr = 3'd7;
        wr_data = 4'd0;
        start = 1'b1;
      end else begin
        wr_en = 1'b0;
        start = 1'b0;
      end
      step();
      if (done) begin
        nd++;
        if (lat < 0) lat = n;
      end
    end
    chk("scan_wr_latency", lat, 8);
    chk("scan_wr_ndone", nd, 1);
    chk("scan_wr_max_val", int'(max_val), 7);
    chk("scan_wr_max_idx", int'(max_idx), 7);

    // start beats a same-cycle write in IDLE
    start = 1'b1;
    wr_en = 1'b1;
    wr_addr = 3'd0;
    wr_data = 4'd15;
    step();
    start = 1'b0;
    wr_en = 1'b0;
    wait_done(lat);
    chk("prio_latency", lat, 8);
    chk("prio_max_val", int'(max_val), 7);
    chk("prio_max_idx", int'(max_idx), 7);

    // write in DONE, then back-to-back restart from DONE
    load(32'h170FF293);
    go(lat);
    chk("b2b_a_max_idx", int'(max_idx), 3);
    wr(2, 15);
    go(lat);
    chk("b2b_b_latency", lat, 8);
    chk("b2b_b_max_val", int'(max_val), 15);
    chk("b2b_b_max_idx", int'(max_idx), 2);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("b2b_c_busy", int'(busy), 1);
    chk("b2b_c_done", int'(done), 0);
    wait_done(lat);
    chk("b2b_c_latency", lat, 8);
    chk("b2b_c_max_idx", int'(max_idx), 2);

    // asynchronous reset in the middle of a scan
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_max_val", int'(max_val), 0);
    chk("abort_max_idx", int'(max_idx), 0);
    #2;
    rst_n = 1'b1;
    nd = 0;
    for (int n = 0; n < 12; n++) begin
      step();
      if (done) nd++;
    end
    chk("abort_no_done", nd, 0);
    wr(6, 12);
    go(lat);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_max_val", int'(max_val), 12);
    chk("post_rst_max_idx", int'(max_idx), 6);
`ifdef MAX_SCAN_TRACK_MIN_EN
    chk("post_rst_min_val", int'(min_val), 0);
    chk("post_rst_min_idx", int'(min_idx), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/max_scan_ctrl.md
MAX_SCAN_CTRL -- requirements
Module: max_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, data width of each entry and of the greater-than comparison.
REQ-002 SHALL have parameter DEPTH, default 8, number of entries in the buffer (power of two, minimum 2).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port wr_en  input  1  write strobe for the entry buffer.
REQ-006 SHALL have port wr_addr  input  log2(DEPTH)  entry index to write.
REQ-007 SHALL have port wr_data  input  WIDTH  unsigned value to write.
REQ-008 SHALL have port start  input  1  request a scan of all entries.
REQ-009 SHALL have port busy  output  1  high while a scan is in progress.
REQ-010 SHALL have port done  output  1  single-cycle pulse when a scan completes.
REQ-011 SHALL have port max_val  output  WIDTH  largest entry found by the last completed scan.
REQ-012 SHALL have port max_idx  output  log2(DEPTH)  index of max_val.

Function
REQ-013 SHALL implement FSM states IDLE, SCAN, DONE; transitions: IDLE/DONE --start--> SCAN; SCAN --last compare--> DONE; DONE --no start--> IDLE after one cycle.
REQ-014 SHALL accept start only in IDLE or DONE; start in SCAN is ignored.
REQ-015 SHALL on an accepted start load the running best from entry 0 (index 0) and set the compare pointer to 1.
REQ-016 SHALL in SCAN perform one unsigned strict greater-than compare per cycle (mem[ptr] > best); on true, best and best index take mem[ptr] and ptr.
REQ-017 SHALL keep the lower index on ties (equal values never replace best).
REQ-018 SHALL assert done exactly once, DEPTH cycles after the edge that accepted start (DEPTH-1 compare cycles plus one output-register cycle).
REQ-019 SHALL update max_val and max_idx in the same cycle done is asserted and hold them until the next done.
REQ-020 SHALL assert busy from the cycle after start is accepted through the last SCAN cycle, and deassert it in the cycle done is high.
REQ-021 SHALL commit writes only in IDLE or DONE; wr_en in SCAN is ignored (entries are frozen during a scan).
REQ-022 SHALL ignore wr_en in the cycle an accepted start is sampled; start has priority.
REQ-023 SHALL start a new scan directly from DONE when start is high in the done cycle, with no IDLE cycle.
REQ-024 SHALL never wrap the pointer: the scan ends after index DEPTH-1.

Reset
REQ-025 SHALL on rst_n low, independent of clk, force state IDLE, pointer 0, all entries 0, busy 0, done 0, max_val 0, max_idx 0.
REQ-026 SHALL abort a scan in progress on reset with no done pulse; outputs read 0 after reset.
REQ-027 SHALL resume operation on the first rising clk edge after rst_n deasserts.

Configuration
REQ-028 SHALL, when macro MAX_SCAN_TRACK_MIN_EN is defined, add outputs min_val (WIDTH) and min_idx (log2(DEPTH)), tracked in the same scan by replacing best-min when best-min > mem[ptr] (ties keep lower index), updated with done, reset to 0.
REQ-029 SHALL, when MAX_SCAN_TRACK_MIN_EN is undefined, have no min ports or min logic; all other behaviour identical.

Verification
REQ-030 Entries {3,9,2,15,15,0,7,1}, pulse start -> done pulses 8 cycles after start is accepted, max_val=15, max_idx=3 (tie to lower index).
REQ-031 All entries 5 -> max_val=5, max_idx=0; with MAX_SCAN_TRACK_MIN_EN min_val=5, min_idx=0.
REQ-032 Entries {0,1,...,7}, start; during SCAN write wr_addr=7, wr_data=0, and pulse start again -> write and second start ignored, max_val=7, max_idx=7, single done.
REQ-033 After REQ-030 scan, start held high in done cycle with entry 2 rewritten to 15 earlier in DONE... (write in DONE, then start) -> second scan runs without IDLE gap, max_idx=2.
REQ-034 rst_n low at 3rd SCAN cycle -> busy, done, max_val, max_idx all 0 immediately, no done pulse; fresh write of entry 6=12 and start -> max_val=12, max_idx=6.
